// File: rtl/ard_link_pkg.sv
// Shared definitions for the Arduino link blocks: sequencer state encoding,
// default strobe timing and small elaboration-time helpers.
package ard_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } link_state_e;

    // 0.1 s strobe and 10 ms gap at a 12 MHz link clock
    localparam int DEF_HOLD_CYCLES = 1200000;
    localparam int DEF_GAP_CYCLES  = 120000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases; expired is high
// while the count sits at zero.
module hold_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count_r;

    // Down-counter: reload wins, otherwise count towards zero and park there.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end
    end

    assign expired = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ard_seq_sender.sv
// Sends a latched multi-digit payload to an Arduino one digit at a time,
// each digit qualified by a timed strobe with optional gaps between digits.
module ard_seq_sender
    import ard_link_pkg::*;
#(
    parameter  int DATA_W      = 4,
    parameter  int NUM_DIGITS  = 4,
    parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter  int GAP_CYCLES  = DEF_GAP_CYCLES,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int PAY_W       = NUM_DIGITS * DATA_W
) (
    input  logic              hwclk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAY_W-1:0]  digits,
    input  logic              abort,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  digit_idx
);

    localparam int               CNT_W     = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    link_state_e       state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [PAY_W-1:0]  shadow_r, shadow_s;
    logic              load_s;
    logic [CNT_W-1:0]  load_val_s;
    logic              expired_s;
    logic [DATA_W-1:0] data_out_r;
    logic              strobe_r, busy_r, done_r;

    hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (hwclk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .expired  (expired_s)
    );

    // Next-state, digit index, shadow capture and timer reload decisions.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        shadow_s   = shadow_r;
        load_s     = 1'b0;
        load_val_s = HOLD_LOAD;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_HOLD;
                    idx_s    = {IDX_W{1'b0}};
                    shadow_s = digits;
                    load_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (expired_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_s    = ST_GAP;
                        load_s     = 1'b1;
                        load_val_s = GAP_LOAD;
                    end else begin
                        // no gap: next digit goes out on the same edge
                        state_s = ST_HOLD;
                        idx_s   = idx_r + IDX_W'(1);
                        load_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (expired_s) begin
                    state_s = ST_HOLD;
                    idx_s   = idx_r + IDX_W'(1);
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, index and payload shadow registers.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= {IDX_W{1'b0}};
            shadow_r <= {PAY_W{1'b0}};
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            shadow_r <= shadow_s;
        end
    end

    // Outputs registered from the next state so they line up with it;
    // data_out only changes when a digit enters HOLD.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            data_out_r <= {DATA_W{1'b0}};
            strobe_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (state_s == ST_HOLD) begin
                data_out_r <= shadow_s[int'(idx_s) * DATA_W +: DATA_W];
            end
            strobe_r <= (state_s == ST_HOLD);
            busy_r   <= (state_s == ST_HOLD) || (state_s == ST_GAP);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign data_out  = data_out_r;
    assign strobe    = strobe_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign digit_idx = idx_r;

endmodule

// File: tb/tb_ard_seq_sender.sv
// Scoreboard bench: per-cycle expected output records are queued when a
// transaction is launched and compared on each falling clock edge.
module tb_ard_seq_sender;

    typedef struct packed {
        logic       strobe;
        logic       busy;
        logic       done;
        logic [3:0] data;
        logic [1:0] idx;
        logic       idx_vld;
    } exp_t;

    logic        hwclk = 1'b0;
    logic        rst;
    logic        start0, abort0, start1, abort1;
    logic [11:0] digits0, digits1;
    logic [3:0]  data_out0, data_out1;
    logic        strobe0, strobe1, busy0, busy1, done0, done1;
    logic [1:0]  idx0, idx1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 hwclk = ~hwclk;

    ard_seq_sender #(.DATA_W(4), .NUM_DIGITS(3), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut0 (
        .hwclk(hwclk), .rst(rst), .start(start0), .digits(digits0), .abort(abort0),
        .data_out(data_out0), .strobe(strobe0), .busy(busy0), .done(done0), .digit_idx(idx0)
    );

    ard_seq_sender #(.DATA_W(4), .NUM_DIGITS(3), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut1 (
        .hwclk(hwclk), .rst(rst), .start(start1), .digits(digits1), .abort(abort1),
        .data_out(data_out1), .strobe(strobe1), .busy(busy1), .done(done1), .digit_idx(idx1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic b, input logic d,
                                input logic [3:0] dat, input logic [1:0] idx, input logic iv);
        exp_t e;
        e.strobe = s; e.busy = b; e.done = d; e.data = dat; e.idx = idx; e.idx_vld = iv;
        return e;
    endfunction

    task automatic push_exp(input int which, input exp_t e);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    // Expected trace: optional idle cycle in which start is sampled, then
    // 4 strobe cycles per digit, gap cycles between digits, one done cycle.
    task automatic push_txn(input int which, input logic [11:0] dig, input logic [3:0] lead,
                            input int gap, input bit lead_en);
        logic [3:0] dat;
        if (lead_en) push_exp(which, mk(1'b0, 1'b0, 1'b0, lead, 2'd0, 1'b0));
        for (int d = 0; d < 3; d++) begin
            dat = dig[d*4 +: 4];
            for (int h = 0; h < 4; h++) push_exp(which, mk(1'b1, 1'b1, 1'b0, dat, 2'(d), 1'b1));
            if (d < 2) begin
                for (int g = 0; g < gap; g++) push_exp(which, mk(1'b0, 1'b1, 1'b0, dat, 2'(d), 1'b1));
            end
        end
        dat = dig[11:8];
        push_exp(which, mk(1'b0, 1'b0, 1'b1, dat, 2'd0, 1'b0));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic wait_drain(input int which);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q1.size()) > 0 && n < 300) begin
            @(posedge hwclk);
            n++;
        end
        #1;
        check_eq("drain", (which == 0) ? q0.size() : q1.size(), 32'd0);
    endtask

    always @(negedge hwclk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check_eq("d0.strobe", 32'(strobe0), 32'(e0.strobe));
            check_eq("d0.busy", 32'(busy0), 32'(e0.busy));
            check_eq("d0.done", 32'(done0), 32'(e0.done));
            check_eq("d0.data_out", 32'(data_out0), 32'(e0.data));
            if (e0.idx_vld) check_eq("d0.digit_idx", 32'(idx0), 32'(e0.idx));
        end
    end

    always @(negedge hwclk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check_eq("d1.strobe", 32'(strobe1), 32'(e1.strobe));
            check_eq("d1.busy", 32'(busy1), 32'(e1.busy));
            check_eq("d1.done", 32'(done1), 32'(e1.done));
            check_eq("d1.data_out", 32'(data_out1), 32'(e1.data));
            if (e1.idx_vld) check_eq("d1.digit_idx", 32'(idx1), 32'(e1.idx));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        digits0 = 12'h000; digits1 = 12'h000;
        tick(2);
        push_exp(0, mk(1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b1));
        push_exp(1, mk(1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b1));
        tick(1);
        rst = 1'b0;

        // single transaction with gaps, then idle keeps last digit
        digits0 = 12'h5A3; start0 = 1'b1;
        push_txn(0, 12'h5A3, 4'h0, 2, 1'b1);
        tick(1); start0 = 1'b0;
        wait_drain(0);
        push_exp(0, mk(1'b0, 1'b0, 1'b0, 4'h5, 2'd0, 1'b0));
        tick(1);

        // no-gap instance; abort during DONE must not suppress done
        digits1 = 12'h123; start1 = 1'b1;
        push_txn(1, 12'h123, 4'h0, 0, 1'b1);
        tick(1); start1 = 1'b0;
        tick(12); abort1 = 1'b1;
        tick(1); abort1 = 1'b0;
        push_exp(1, mk(1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 1'b0));
        wait_drain(1);

        // start held: back-to-back, digits changed mid-flight go to next one
        digits0 = 12'h9C7; start0 = 1'b1;
        push_txn(0, 12'h9C7, 4'h5, 2, 1'b1);
        push_txn(0, 12'hE41, 4'h9, 2, 1'b1);
        tick(5); digits0 = 12'hE41;
        wait_drain(0);
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) push_exp(0, mk(1'b0, 1'b0, 1'b0, 4'hE, 2'd0, 1'b0));
        tick(3);

        // abort in the second gap cycle after digit 0
        digits0 = 12'h6B2; start0 = 1'b1;
        push_txn(0, 12'h6B2, 4'hE, 2, 1'b1);
        tick(1); start0 = 1'b0;
        tick(5); abort0 = 1'b1;
        tick(1); abort0 = 1'b0;
        q0.delete();
        for (int i = 0; i < 4; i++) push_exp(0, mk(1'b0, 1'b0, 1'b0, 4'h2, 2'd0, 1'b0));
        tick(4);

        // reset during HOLD of digit 1, restart right after release
        digits0 = 12'h5A3; start0 = 1'b1;
        push_txn(0, 12'h5A3, 4'h2, 2, 1'b1);
        tick(1); start0 = 1'b0;
        tick(7);
        rst = 1'b1;
        while (q0.size() > 1) void'(q0.pop_back());
        push_exp(0, mk(1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b1));
        digits0 = 12'h84F; start0 = 1'b1;
        push_txn(0, 12'h84F, 4'h0, 2, 1'b0);
        tick(1); rst = 1'b0;
        tick(1); start0 = 1'b0;
        wait_drain(0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
